// File: rtl/store_commit_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_commit_buffer
// Purpose  : Drain side of the store queue. Accepts up to N committed stores
//            per cycle from the SQ head window into a small in-order
//            write buffer. Issues them one at a time to data memory over a
//            valid/ready channel. Answers word-granular store-to-load
//            forwarding lookups against buffered stores.
// Ports    : clock, reset              - clock, synchronous active-high reset
//            sq_head_entries_i         - SQ head window, oldest in slot 0
//            sq_head_valids_i          - per-slot valid of the head window
//            rob_store_commits_i       - stores committing this cycle (prefix)
//            commit_ready_count_o      - max stores the ROB may commit now
//            sq_pop_count_o            - head entries the SQ releases now
//            mem_req_*_o / _ready_i    - write request channel to memory
//            fwd_addr_i                - load address for forwarding lookup
//            fwd_hit_o / fwd_data_o    - youngest word match is a full word
//            fwd_conflict_o            - youngest word match is sub-word
//            wb_empty_o                - no buffered stores
// Entry    : {valid, addr[31:0], data[31:0], mem_size[MEM_SIZE-1:0]}, MSB first
// Sizes    : BYTE = 0, HALF = 1, WORD = 2
// Revision : 1.0 - initial release
// ============================================================================
module store_commit_buffer #(
  parameter  int N        = 2,
  parameter  int WB_DEPTH = 4,
  parameter  int MEM_SIZE = 2,
  localparam int ENTRY_W  = 1 + 32 + 32 + MEM_SIZE,
  localparam int KW       = $clog2(N + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N-1:0][ENTRY_W-1:0]      sq_head_entries_i,
  input  logic [N-1:0]                   sq_head_valids_i,
  input  logic [KW-1:0]                  rob_store_commits_i,
  output logic [KW-1:0]                  commit_ready_count_o,
  output logic [KW-1:0]                  sq_pop_count_o,
  output logic                           mem_req_valid_o,
  output logic [31:0]                    mem_req_addr_o,
  output logic [31:0]                    mem_req_data_o,
  output logic [MEM_SIZE-1:0]            mem_req_size_o,
  input  logic                           mem_req_ready_i,
  input  logic [31:0]                    fwd_addr_i,
  output logic                           fwd_hit_o,
  output logic [31:0]                    fwd_data_o,
  output logic                           fwd_conflict_o,
  output logic                           wb_empty_o
);

  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W = $clog2(WB_DEPTH + 1);

  // Field positions inside one head-window entry
  localparam int F_VALID  = ENTRY_W - 1;
  localparam int F_ADDR_H = ENTRY_W - 2;
  localparam int F_DATA_H = MEM_SIZE + 31;

  localparam logic [MEM_SIZE-1:0] SIZE_WORD = MEM_SIZE'(2);
  localparam logic [KW-1:0]       N_K       = KW'(N);

  // Storage
  logic [31:0]         addr_q [WB_DEPTH];
  logic [31:0]         data_q [WB_DEPTH];
  logic [MEM_SIZE-1:0] size_q [WB_DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [KW-1:0]    w_k;
  logic             w_pop;
  logic [KW-1:0]    w_commit_ready;
  logic [CNT_W-1:0] w_free;

  logic [PTR_W-1:0] w_wr_idx [N];
  logic [N-1:0]     w_wr_en;

  logic [PTR_W-1:0]    w_age_idx   [WB_DEPTH];
  logic [WB_DEPTH-1:0] w_age_live;
  logic [WB_DEPTH-1:0] w_age_match;

  logic w_illegal;

  assign w_k   = rob_store_commits_i;
  assign w_pop = (count_q != '0) && mem_req_ready_i;

  // --------------------------------------------------------------------------
  // Commit credit: derived from registered occupancy only, so a drain in the
  // same cycle never frees a slot early and there is no path from ready.
  // --------------------------------------------------------------------------
  always_comb begin
    w_free         = CNT_W'(WB_DEPTH) - count_q;
    w_commit_ready = N_K;
    if (w_free < CNT_W'(N)) begin
      w_commit_ready = KW'(w_free);
    end
  end

  assign commit_ready_count_o = reset ? N_K : w_commit_ready;
  assign sq_pop_count_o       = reset ? '0 : w_k;

  // Per-slot write targets for the accepted prefix of the head window
  for (genvar gi = 0; gi < N; gi++) begin : g_wr
    assign w_wr_idx[gi] = tail_q + PTR_W'(gi);
    assign w_wr_en[gi]  = (KW'(gi) < w_k);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < WB_DEPTH; e++) begin
        addr_q[e] <= '0;
        data_q[e] <= '0;
        size_q[e] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_wr_en[i]) begin
          addr_q[w_wr_idx[i]] <= sq_head_entries_i[i][F_ADDR_H -: 32];
          data_q[w_wr_idx[i]] <= sq_head_entries_i[i][F_DATA_H -: 32];
          size_q[w_wr_idx[i]] <= sq_head_entries_i[i][MEM_SIZE-1:0];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pointers and occupancy; pointer wrap comes from natural overflow.
  // --------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q + PTR_W'(w_pop);
    tail_d  = tail_q + PTR_W'(w_k);
    count_d = count_q + CNT_W'(w_k) - CNT_W'(w_pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Memory request: payload is a direct read of the head entry, so it holds
  // while ready is low. Valid is forced low during reset.
  // --------------------------------------------------------------------------
  assign mem_req_valid_o = !reset && (count_q != '0);
  assign mem_req_addr_o  = addr_q[head_q];
  assign mem_req_data_o  = data_q[head_q];
  assign mem_req_size_o  = size_q[head_q];
  assign wb_empty_o      = (count_q == '0);

  // --------------------------------------------------------------------------
  // Forwarding: age 0 is the oldest entry. Scanning oldest to youngest and
  // letting later matches overwrite earlier ones leaves the youngest match.
  // --------------------------------------------------------------------------
  for (genvar gj = 0; gj < WB_DEPTH; gj++) begin : g_age
    assign w_age_idx[gj]   = head_q + PTR_W'(gj);
    assign w_age_live[gj]  = (CNT_W'(gj) < count_q);
    assign w_age_match[gj] = w_age_live[gj] &&
                             (addr_q[w_age_idx[gj]][31:2] == fwd_addr_i[31:2]);
  end

  always_comb begin
    fwd_hit_o      = 1'b0;
    fwd_conflict_o = 1'b0;
    fwd_data_o     = '0;
    for (int j = 0; j < WB_DEPTH; j++) begin
      if (w_age_match[j]) begin
        if (size_q[w_age_idx[j]] == SIZE_WORD) begin
          fwd_hit_o      = 1'b1;
          fwd_conflict_o = 1'b0;
          fwd_data_o     = data_q[w_age_idx[j]];
        end else begin
          fwd_hit_o      = 1'b0;
          fwd_conflict_o = 1'b1;
          fwd_data_o     = '0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Commit protocol check: the ROB may not exceed the offered credit and may
  // only commit valid head-window slots.
  // --------------------------------------------------------------------------
  always_comb begin
    w_illegal = (w_k > w_commit_ready);
    for (int i = 0; i < N; i++) begin
      if (w_wr_en[i] && !(sq_head_valids_i[i] && sq_head_entries_i[i][F_VALID])) begin
        w_illegal = 1'b1;
      end
    end
  end

  a_commit_legal : assert property (@(posedge clock) disable iff (reset) !w_illegal);

  // Byte offset bits do not take part in the word-granular match
  logic w_unused;
  assign w_unused = &{1'b0, fwd_addr_i[1:0]};

endmodule
`default_nettype wire
